// File: rtl/bcd_ctrl_pkg.sv
// Shared types and helpers for the three-decade BCD count controller.
// Holds the FSM and op-code encodings plus BCD digit utilities.
package bcd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_LOAD  = 2'd1,
    OP_START = 2'd2,
    OP_STOP  = 2'd3
  } op_e;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t hundreds;
    bcd_digit_t tens;
    bcd_digit_t units;
  } bcd3_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic logic is_bcd(input bcd3_t v);
    return (v.hundreds <= BCD_MAX) && (v.tens <= BCD_MAX) && (v.units <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: clear beats load beats count; carry flags a 9->0 roll
// so the next decade can be enabled in the same cycle.
module bcd_digit
  import bcd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       clear,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = en && (q == BCD_MAX);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            q <= '0;
    else if (clear)     q <= '0;
    else if (load)      q <= load_val;
    else if (en)        q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
  end

endmodule

// File: rtl/bcd_count_ctrl.sv
// Command-driven three-digit BCD counter: CLEAR/LOAD/START/STOP decode,
// target register and completion compare around a chain of bcd_digit decades.
module bcd_count_ctrl
  import bcd_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [11:0] cmd_data,
  input  logic        tick,
  output logic [3:0]  units,
  output logic [3:0]  tens,
  output logic [3:0]  hundreds,
  output logic [1:0]  state,
  output logic        done,
  output logic        err
);

  state_e state_q, state_n;
  bcd3_t  target_q;
  bcd3_t  cnt, next_cnt, data;
  op_e    op;
  logic   ready_q, done_q, err_q;
  logic   accept, run_tick;
  logic   clr_cnt, load_cnt, tgt_we, done_n, err_n;
  logic   carry_u, carry_t, carry_h;

  assign data   = cmd_data;
  assign op     = op_e'(cmd_op);
  assign accept = cmd_valid && ready_q;
  // An accepted command always wins over a tick in the same cycle.
  assign run_tick = (state_q == ST_RUN) && tick && !accept;

  bcd_digit u_units (
    .clk(clk), .rst(rst), .en(run_tick), .load(load_cnt), .load_val(data.units),
    .clear(clr_cnt), .q(cnt.units), .carry(carry_u)
  );

  bcd_digit u_tens (
    .clk(clk), .rst(rst), .en(carry_u), .load(load_cnt), .load_val(data.tens),
    .clear(clr_cnt), .q(cnt.tens), .carry(carry_t)
  );

  bcd_digit u_hundreds (
    .clk(clk), .rst(rst), .en(carry_t), .load(load_cnt), .load_val(data.hundreds),
    .clear(clr_cnt), .q(cnt.hundreds), .carry(carry_h)
  );

  // Post-increment value, valid whenever run_tick is high.
  always_comb begin
    next_cnt.units    = carry_u ? 4'd0 : cnt.units + 4'd1;
    next_cnt.tens     = carry_u ? (carry_t ? 4'd0 : cnt.tens + 4'd1) : cnt.tens;
    next_cnt.hundreds = carry_t ? (carry_h ? 4'd0 : cnt.hundreds + 4'd1) : cnt.hundreds;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  // NOTE: every output of this block is defaulted first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n  = state_q;
    clr_cnt  = 1'b0;
    load_cnt = 1'b0;
    tgt_we   = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    if (accept) begin
      unique case (op)
        OP_CLEAR: begin
          clr_cnt = 1'b1;
          state_n = ST_IDLE;
        end
        OP_LOAD: begin
          if (!is_bcd(data)) err_n = 1'b1;
          else begin
            load_cnt = 1'b1;
            state_n  = ST_IDLE;
          end
        end
        OP_START: begin
          if (!is_bcd(data)) err_n = 1'b1;
          else if (state_q != ST_RUN) begin
            tgt_we  = 1'b1;
            clr_cnt = (state_q == ST_DONE);
            state_n = ST_RUN;
          end
        end
        OP_STOP: begin
          if (state_q == ST_RUN) state_n = ST_PAUSE;
        end
        default: ;
      endcase
    end else if (run_tick && (next_cnt == target_q)) begin
      // Only a real increment can complete, so target==count at START needs a full wrap.
      state_n = ST_DONE;
      done_n  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (tgt_we) target_q <= data;
      ready_q <= 1'b1;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  assign cmd_ready = ready_q;
  assign units     = cnt.units;
  assign tens      = cnt.tens;
  assign hundreds  = cnt.hundreds;
  assign state     = state_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl: directed scenarios plus a randomized run
// checked against an integer-arithmetic model of the counter.
module tb_bcd_count_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [11:0] cmd_data = 12'h000;
  logic        tick = 1'b0;
  logic [3:0]  units, tens, hundreds;
  logic [1:0]  state;
  logic        done, err;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] CLR = 2'd0, LD = 2'd1, ST = 2'd2, SP = 2'd3;
  localparam int IDLE = 0, RUN = 1, PAUSE = 2, DN = 3;

  // Reference model state: plain integers.
  int m_count, m_target, m_state;
  bit m_done, m_err, m_ready;

  bcd_count_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .tick(tick),
    .units(units), .tens(tens), .hundreds(hundreds),
    .state(state), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  wire [11:0] cnt = {hundreds, tens, units};

  function automatic bit valid_bcd(input logic [11:0] d);
    return (d[11:8] < 10) && (d[7:4] < 10) && (d[3:0] < 10);
  endfunction

  function automatic int bcd_to_int(input logic [11:0] d);
    return int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]);
  endfunction

  function automatic logic [11:0] int_to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [16:0] model_vec();
    return {2'(m_state), m_done, m_err, m_ready, int_to_bcd(m_count)};
  endfunction

  task automatic model_reset();
    m_count = 0; m_target = 0; m_state = IDLE;
    m_done = 0; m_err = 0; m_ready = 0;
  endtask

  task automatic model_step(input bit v, input logic [1:0] op, input logic [11:0] d, input bit tk);
    m_done = 0;
    m_err  = 0;
    if (v && m_ready) begin
      case (op)
        CLR: begin m_count = 0; m_state = IDLE; end
        LD: if (!valid_bcd(d)) m_err = 1;
            else begin m_count = bcd_to_int(d); m_state = IDLE; end
        ST: if (!valid_bcd(d)) m_err = 1;
            else if (m_state != RUN) begin
              m_target = bcd_to_int(d);
              if (m_state == DN) m_count = 0;
              m_state = RUN;
            end
        default: if (m_state == RUN) m_state = PAUSE;
      endcase
    end else if (m_state == RUN && tk) begin
      m_count = (m_count + 1) % 1000;
      if (m_count == m_target) begin m_state = DN; m_done = 1; end
    end
    m_ready = 1;
  endtask

  task automatic step(input bit v, input logic [1:0] op, input logic [11:0] d, input bit tk);
    cmd_valid = v; cmd_op = op; cmd_data = d; tick = tk;
    @(posedge clk);
    model_step(v, op, d, tk);
    #1;
    cmd_valid = 1'b0; tick = 1'b0;
  endtask

  task automatic assert_rst();
    #1 rst = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic test_reset();
    assert_rst();
    n_checks++;
    if ({cnt, state, done, err, cmd_ready} !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_values got cnt=%h st=%0d done=%b err=%b rdy=%b want all zero",
               cnt, state, done, err, cmd_ready);
    end
    release_rst();
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge got %b want 0", cmd_ready); end
    step(0, CLR, 12'h0, 0);
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge got %b want 1", cmd_ready); end
  endtask

  task automatic test_load_start();
    step(1, LD, 12'h123, 0);
    n_checks++;
    if (cnt !== 12'h123 || state !== 2'd0) begin n_fail++; $display("FAIL load_123 got %h/%0d want 123/0", cnt, state); end
    step(1, ST, 12'h125, 0);
    n_checks++;
    if (cnt !== 12'h123 || state !== 2'd1) begin n_fail++; $display("FAIL start_125 got %h/%0d want 123/1", cnt, state); end
    step(0, CLR, 12'h0, 1);
    n_checks++;
    if (cnt !== 12'h124 || done !== 1'b0) begin n_fail++; $display("FAIL tick_124 got %h done=%b want 124 done=0", cnt, done); end
    step(0, CLR, 12'h0, 1);
    n_checks++;
    if (cnt !== 12'h125 || done !== 1'b1 || state !== 2'd3) begin
      n_fail++; $display("FAIL tick_125 got %h done=%b st=%0d want 125 done=1 st=3", cnt, done, state);
    end
    step(0, CLR, 12'h0, 1);
    n_checks++;
    if (cnt !== 12'h125 || done !== 1'b0 || state !== 2'd3) begin
      n_fail++; $display("FAIL done_hold got %h done=%b st=%0d want 125 done=0 st=3", cnt, done, state);
    end
  endtask

  task automatic test_wrap();
    logic [11:0] exp_seq [4];
    exp_seq = '{12'h999, 12'h000, 12'h001, 12'h002};
    step(1, LD, 12'h998, 0);
    step(1, ST, 12'h002, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, CLR, 12'h0, 1);
      n_checks++;
      if (cnt !== exp_seq[i] || done !== (i == 3)) begin
        n_fail++; $display("FAIL wrap_%0d got %h done=%b want %h done=%b", i, cnt, done, exp_seq[i], i == 3);
      end
    end
  endtask

  task automatic test_err();
    step(1, LD, 12'h1A0, 0);
    n_checks++;
    if (err !== 1'b1 || cnt !== 12'h002 || state !== 2'd3) begin
      n_fail++; $display("FAIL load_bad got err=%b %h st=%0d want err=1 002 st=3", err, cnt, state);
    end
    step(0, CLR, 12'h0, 0);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width got %b want 0", err); end
    step(1, ST, 12'h0F0, 0);
    n_checks++;
    if (err !== 1'b1 || state !== 2'd3 || cnt !== 12'h002) begin
      n_fail++; $display("FAIL start_bad got err=%b st=%0d %h want err=1 st=3 002", err, state, cnt);
    end
  endtask

  task automatic test_pause();
    step(1, CLR, 12'h0, 0);
    step(1, LD, 12'h050, 0);
    step(1, ST, 12'h999, 0);
    step(1, SP, 12'h0, 0);
    n_checks++;
    if (state !== 2'd2) begin n_fail++; $display("FAIL stop_to_pause got st=%0d want 2", state); end
    repeat (5) step(0, CLR, 12'h0, 1);
    n_checks++;
    if (cnt !== 12'h050 || state !== 2'd2) begin n_fail++; $display("FAIL pause_hold got %h st=%0d want 050 st=2", cnt, state); end
    step(1, ST, 12'h999, 0);
    step(0, CLR, 12'h0, 1);
    n_checks++;
    if (cnt !== 12'h051 || state !== 2'd1) begin n_fail++; $display("FAIL resume got %h st=%0d want 051 st=1", cnt, state); end
  endtask

  task automatic test_priority();
    step(1, CLR, 12'h0, 0);
    step(1, ST, 12'h005, 1);
    n_checks++;
    if (cnt !== 12'h000 || state !== 2'd1) begin n_fail++; $display("FAIL start_with_tick got %h st=%0d want 000 st=1", cnt, state); end
    step(0, CLR, 12'h0, 1);
    step(1, CLR, 12'h0, 1);
    n_checks++;
    if (cnt !== 12'h000 || state !== 2'd0) begin n_fail++; $display("FAIL clear_with_tick got %h st=%0d want 000 st=0", cnt, state); end
  endtask

  task automatic test_full_wrap();
    int n = 0;
    step(1, CLR, 12'h0, 0);
    step(1, ST, 12'h000, 0);
    while (n < 1100) begin
      step(0, CLR, 12'h0, 1);
      n++;
      if (done === 1'b1) break;
    end
    n_checks++;
    if (n != 1000 || cnt !== 12'h000 || state !== 2'd3) begin
      n_fail++; $display("FAIL full_wrap got %0d ticks cnt=%h st=%0d want 1000 ticks 000 st=3", n, cnt, state);
    end
  endtask

  task automatic test_reset_mid_run();
    step(1, LD, 12'h437, 0);
    step(1, ST, 12'h999, 0);
    assert_rst();
    n_checks++;
    if (cnt !== 12'h000 || state !== 2'd0 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got %h st=%0d rdy=%b want 000 st=0 rdy=0", cnt, state, cmd_ready);
    end
    release_rst();
    step(0, CLR, 12'h0, 0);
    step(1, ST, 12'h001, 0);
    step(0, CLR, 12'h0, 1);
    n_checks++;
    if (cnt !== 12'h001 || done !== 1'b1 || state !== 2'd3) begin
      n_fail++; $display("FAIL post_reset_run got %h done=%b st=%0d want 001 done=1 st=3", cnt, done, state);
    end
  endtask

  task automatic test_random();
    logic [16:0] obs;
    logic [11:0] d;
    logic [1:0]  op;
    bit v;
    int errs = 0;
    assert_rst();
    release_rst();
    for (int i = 0; i < 3000; i++) begin
      v  = ($urandom_range(0, 99) < 25);
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)      d = 12'($urandom);
      else if ($urandom_range(0, 1) == 0) d = int_to_bcd((m_count + $urandom_range(1, 15)) % 1000);
      else                                d = int_to_bcd($urandom_range(0, 999));
      step(v, op, d, $urandom_range(0, 99) < 70);
      obs = {state, done, err, cmd_ready, cnt};
      n_checks++;
      if (obs !== model_vec()) begin
        n_fail++;
        if (errs++ < 10) $display("FAIL random_%0d got %h want %h", i, obs, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_start();
    test_wrap();
    test_err();
    test_pause();
    test_priority();
    test_full_wrap();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
